inst_fetch: RTL and testbench

- Fetch-stage initiator that drives the instruction ROM.
- Owns the PC register and issues word addresses to the ROM, whose read data returns combinationally in the same cycle.
- Captures each {pc, inst} pair into a small prefetch FIFO.
- Presents the FIFO head to decode through a valid/ready handshake, with branch redirect and flush.

---
 rtl/inst_fetch.sv | 132 +++++++++++++
 tb/tb_inst_fetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: fetch-stage initiator for the instruction ROM.
// Holds the PC, reads the ROM (which answers in the same cycle), queues
// {pc, inst} pairs in a small prefetch FIFO and hands the FIFO head to decode
// over a valid/ready handshake. A branch redirect flushes the queue.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a
// misaligned redirect parks the fetcher and raises misalign_o.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        id_valid_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  input  logic        id_ready_i
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  logic [31:0]      pc;
  logic             ce_q;
  logic [31:0]      mem_pc   [BUF_DEPTH];
  logic [31:0]      mem_inst [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push;
  logic             fetch_en;
  logic [31:0]      redirect_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  // The raw target is kept so the faulting address stays on rom_addr_o.
  assign redirect_pc = branch_target_i;
  assign fetch_en    = ce_q & ~misalign_q;
  assign misalign_o  = misalign_q;

  // Misalign flag: set or cleared by every redirect, depending on the target's low bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (branch_flag_i) begin
      misalign_q <= |branch_target_i[1:0];
    end
  end
`else
  logic unused_target_lsbs;

  // Without the trap the low target bits are forced to zero, so fetch keeps going.
  assign redirect_pc        = {branch_target_i[31:2], 2'b00};
  assign fetch_en           = ce_q;
  assign unused_target_lsbs = ^branch_target_i[1:0];
`endif

  assign rom_ce_o   = fetch_en;
  assign rom_addr_o = pc;

  // A head entry is consumed when decode takes it. A fetched word is queued
  // when there is room, or when the head leaves in the same cycle.
  assign full       = (count == DEPTH_C);
  assign id_valid_o = (count != '0);
  assign pop        = id_valid_o & id_ready_i;
  assign push       = fetch_en & ~branch_flag_i & (~full | pop);

  assign id_inst_o  = id_valid_o ? mem_inst[rd_ptr] : 32'h0;
  assign id_pc_o    = id_valid_o ? mem_pc[rd_ptr]   : 32'h0;

  // ROM enable: starts on the first edge out of reset and stays on.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q <= 1'b0;
    end else begin
      ce_q <= 1'b1;
    end
  end

  // PC: reset, then redirect, then advance one word on each queued fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (branch_flag_i) begin
      pc <= redirect_pc;
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  // FIFO storage: write the current {pc, inst} pair at the tail.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_pc[wr_ptr]   <= pc;
      mem_inst[wr_ptr] <= rom_inst_i;
    end
  end

  // FIFO bookkeeping: a redirect drops everything queued, including a head taken this cycle.
  always_ff @(posedge clk) begin
    if (rst || branch_flag_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed self-checking bench for inst_fetch.
// A behavioural ROM returns 32'hC0DE_0000 ^ word-aligned address, so every
// expected instruction below is a hand-computed constant. A second instance
// with RESET_PC = 32'hFFFF_FFFC covers PC wrap-around.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
  logic        w_misalign;
`endif

  logic        w_rom_ce;
  logic [31:0] w_rom_addr;
  logic [31:0] w_rom_inst;
  logic        w_id_valid;
  logic [31:0] w_id_inst;
  logic [31:0] w_id_pc;

  int tests;
  int errors;

  // Behavioural ROM: same-cycle read data, low address bits ignored.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    rom_word = 32'hC0DE_0000 ^ {a[31:2], 2'b00};
  endfunction

  assign rom_inst   = rom_word(rom_addr);
  assign w_rom_inst = rom_word(w_rom_addr);

  inst_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rom_ce_o(rom_ce), .rom_addr_o(rom_addr),
    .rom_inst_i(rom_inst), .branch_flag_i(branch_flag),
    .branch_target_i(branch_target), .id_valid_o(id_valid),
    .id_inst_o(id_inst), .id_pc_o(id_pc), .id_ready_i(id_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .misalign_o(misalign)
`endif
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_wrap (
    .clk(clk), .rst(rst), .rom_ce_o(w_rom_ce), .rom_addr_o(w_rom_addr),
    .rom_inst_i(w_rom_inst), .branch_flag_i(1'b0),
    .branch_target_i(32'h0), .id_valid_o(w_id_valid),
    .id_inst_o(w_id_inst), .id_pc_o(w_id_pc), .id_ready_i(1'b1)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .misalign_o(w_misalign)
`endif
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, then release it with the given ready level.
  task automatic apply_reset(input logic rdy);
    rst = 1'b1; branch_flag = 1'b0; branch_target = 32'h0; id_ready = rdy;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; branch_flag = 1'b0; branch_target = 32'h0; id_ready = 1'b1;
    tick(); tick();
    tests++; if (rom_ce !== 1'b0) begin errors++; $display("[TB] FAIL reset_ce: got %0b expected 0", rom_ce); end
    tests++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", id_valid); end
    tests++; if (id_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 00000000", id_inst); end
    tests++; if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 00000000", id_pc); end
    tests++; if (rom_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00000000", rom_addr); end
    tests++; if (w_rom_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL reset_wrap_addr: got %h expected fffffffc", w_rom_addr); end
`ifdef FETCH_MISALIGN_TRAP_EN
    tests++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign: got %0b expected 0", misalign); end
`endif
  endtask

  task automatic test_fetch();
    apply_reset(1'b1);
    tick();
    tests++; if (rom_ce !== 1'b1) begin errors++; $display("[TB] FAIL fetch_ce: got %0b expected 1", rom_ce); end
    tests++; if (rom_addr !== 32'h0) begin errors++; $display("[TB] FAIL fetch_addr0: got %h expected 00000000", rom_addr); end
    tests++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_valid0: got %0b expected 0", id_valid); end
    tick();
    tests++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL fetch_valid1: got %0b expected 1", id_valid); end
    tests++; if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL fetch_pcA: got %h expected 00000000", id_pc); end
    tests++; if (id_inst !== 32'hC0DE_0000) begin errors++; $display("[TB] FAIL fetch_instA: got %h expected c0de0000", id_inst); end
    tests++; if (w_id_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_pc0: got %h expected fffffffc", w_id_pc); end
    tests++; if (w_id_inst !== 32'h3F21_FFFC) begin errors++; $display("[TB] FAIL wrap_inst0: got %h expected 3f21fffc", w_id_inst); end
    tick();
    tests++; if (id_pc !== 32'h4) begin errors++; $display("[TB] FAIL fetch_pcB: got %h expected 00000004", id_pc); end
    tests++; if (id_inst !== 32'hC0DE_0004) begin errors++; $display("[TB] FAIL fetch_instB: got %h expected c0de0004", id_inst); end
    tests++; if (w_id_pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc1: got %h expected 00000000", w_id_pc); end
    tests++; if (w_id_inst !== 32'hC0DE_0000) begin errors++; $display("[TB] FAIL wrap_inst1: got %h expected c0de0000", w_id_inst); end
    tick();
    tests++; if (id_pc !== 32'h8) begin errors++; $display("[TB] FAIL fetch_pcC: got %h expected 00000008", id_pc); end
    tests++; if (id_inst !== 32'hC0DE_0008) begin errors++; $display("[TB] FAIL fetch_instC: got %h expected c0de0008", id_inst); end
  endtask

  task automatic test_stall();
    apply_reset(1'b0);
    repeat (5) tick();
    tests++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid: got %0b expected 1", id_valid); end
    tests++; if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL stall_head: got %h expected 00000000", id_pc); end
    tests++; if (id_inst !== 32'hC0DE_0000) begin errors++; $display("[TB] FAIL stall_inst: got %h expected c0de0000", id_inst); end
    tests++; if (rom_addr !== 32'h8) begin errors++; $display("[TB] FAIL stall_addr: got %h expected 00000008", rom_addr); end
    id_ready = 1'b1;
    tick();
    tests++; if (id_pc !== 32'h4) begin errors++; $display("[TB] FAIL drain_pc4: got %h expected 00000004", id_pc); end
    tests++; if (id_inst !== 32'hC0DE_0004) begin errors++; $display("[TB] FAIL drain_inst4: got %h expected c0de0004", id_inst); end
    tick();
    tests++; if (id_pc !== 32'h8) begin errors++; $display("[TB] FAIL drain_pc8: got %h expected 00000008", id_pc); end
    tests++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL drain_valid: got %0b expected 1", id_valid); end
  endtask

  task automatic test_full_push_pop();
    apply_reset(1'b0);
    repeat (4) tick();
    tests++; if (rom_addr !== 32'h8) begin errors++; $display("[TB] FAIL full_addr: got %h expected 00000008", rom_addr); end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    tests++; if (id_pc !== 32'h4) begin errors++; $display("[TB] FAIL pp_head: got %h expected 00000004", id_pc); end
    tests++; if (rom_addr !== 32'hC) begin errors++; $display("[TB] FAIL pp_addr: got %h expected 0000000c", rom_addr); end
    tick();
    tests++; if (rom_addr !== 32'hC) begin errors++; $display("[TB] FAIL pp_hold_addr: got %h expected 0000000c", rom_addr); end
    tests++; if (id_pc !== 32'h4) begin errors++; $display("[TB] FAIL pp_hold_head: got %h expected 00000004", id_pc); end
    id_ready = 1'b1;
    tick();
    tests++; if (id_pc !== 32'h8) begin errors++; $display("[TB] FAIL pp_next8: got %h expected 00000008", id_pc); end
    tick();
    tests++; if (id_pc !== 32'hC) begin errors++; $display("[TB] FAIL pp_next12: got %h expected 0000000c", id_pc); end
    tests++; if (id_inst !== 32'hC0DE_000C) begin errors++; $display("[TB] FAIL pp_inst12: got %h expected c0de000c", id_inst); end
  endtask

  task automatic test_branch();
    apply_reset(1'b0);
    repeat (4) tick();
    branch_flag = 1'b1; branch_target = 32'h40; id_ready = 1'b1;
    tick();
    branch_flag = 1'b0;
    tests++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL br_valid: got %0b expected 0", id_valid); end
    tests++; if (rom_addr !== 32'h40) begin errors++; $display("[TB] FAIL br_addr: got %h expected 00000040", rom_addr); end
    tick();
    tests++; if (id_pc !== 32'h40) begin errors++; $display("[TB] FAIL br_pc: got %h expected 00000040", id_pc); end
    tests++; if (id_inst !== 32'hC0DE_0040) begin errors++; $display("[TB] FAIL br_inst: got %h expected c0de0040", id_inst); end
    tick();
    tests++; if (id_pc !== 32'h44) begin errors++; $display("[TB] FAIL br_pc_next: got %h expected 00000044", id_pc); end
  endtask

  task automatic test_back_to_back();
    branch_flag = 1'b1; branch_target = 32'h100;
    tick();
    branch_target = 32'h200;
    tick();
    branch_flag = 1'b0;
    tests++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_valid: got %0b expected 0", id_valid); end
    tests++; if (rom_addr !== 32'h200) begin errors++; $display("[TB] FAIL b2b_addr: got %h expected 00000200", rom_addr); end
    tick();
    tests++; if (id_pc !== 32'h200) begin errors++; $display("[TB] FAIL b2b_pc: got %h expected 00000200", id_pc); end
    tests++; if (id_inst !== 32'hC0DE_0200) begin errors++; $display("[TB] FAIL b2b_inst: got %h expected c0de0200", id_inst); end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; branch_flag = 1'b1; branch_target = 32'h300;
    tick();
    branch_flag = 1'b0;
    tests++; if (rom_ce !== 1'b0) begin errors++; $display("[TB] FAIL mrst_ce: got %0b expected 0", rom_ce); end
    tests++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL mrst_valid: got %0b expected 0", id_valid); end
    tests++; if (rom_addr !== 32'h0) begin errors++; $display("[TB] FAIL mrst_addr: got %h expected 00000000", rom_addr); end
    rst = 1'b0;
    tick();
    tick();
    tests++; if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL mrst_pc: got %h expected 00000000", id_pc); end
    tests++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL mrst_valid1: got %0b expected 1", id_valid); end
  endtask

  task automatic test_misalign();
    apply_reset(1'b1);
    repeat (3) tick();
    branch_flag = 1'b1; branch_target = 32'h42;
    tick();
    branch_flag = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    tests++; if (misalign !== 1'b1) begin errors++; $display("[TB] FAIL mis_flag: got %0b expected 1", misalign); end
    tests++; if (rom_ce !== 1'b0) begin errors++; $display("[TB] FAIL mis_ce: got %0b expected 0", rom_ce); end
    tests++; if (rom_addr !== 32'h42) begin errors++; $display("[TB] FAIL mis_addr: got %h expected 00000042", rom_addr); end
    repeat (3) tick();
    tests++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_no_entry: got %0b expected 0", id_valid); end
    tests++; if (rom_addr !== 32'h42) begin errors++; $display("[TB] FAIL mis_hold_addr: got %h expected 00000042", rom_addr); end
    branch_flag = 1'b1; branch_target = 32'h80;
    tick();
    branch_flag = 1'b0;
    tests++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL mis_clear: got %0b expected 0", misalign); end
    tests++; if (rom_ce !== 1'b1) begin errors++; $display("[TB] FAIL mis_ce_back: got %0b expected 1", rom_ce); end
    tests++; if (rom_addr !== 32'h80) begin errors++; $display("[TB] FAIL mis_addr80: got %h expected 00000080", rom_addr); end
    tick();
    tests++; if (id_pc !== 32'h80) begin errors++; $display("[TB] FAIL mis_pc80: got %h expected 00000080", id_pc); end
    tests++; if (id_inst !== 32'hC0DE_0080) begin errors++; $display("[TB] FAIL mis_inst80: got %h expected c0de0080", id_inst); end
`else
    tests++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL align_valid: got %0b expected 0", id_valid); end
    tests++; if (rom_addr !== 32'h40) begin errors++; $display("[TB] FAIL align_addr: got %h expected 00000040", rom_addr); end
    tick();
    tests++; if (id_pc !== 32'h40) begin errors++; $display("[TB] FAIL align_pc: got %h expected 00000040", id_pc); end
    tests++; if (id_inst !== 32'hC0DE_0040) begin errors++; $display("[TB] FAIL align_inst: got %h expected c0de0040", id_inst); end
`endif
  endtask

  // Scenario sequence and summary.
  initial begin
    tests = 0; errors = 0;
    rst = 1'b1; branch_flag = 1'b0; branch_target = 32'h0; id_ready = 1'b0;
    test_reset();
    test_fetch();
    test_stall();
    test_full_push_pop();
    test_branch();
    test_back_to_back();
    test_mid_reset();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
